// File: rtl/evr_fifo_ctrl.sv
// evr_fifo_ctrl: EVR elastic FIFO sequencer (reset, prefill, run with level trim, fault recovery)
// clk/resetn: app clock, async active-low reset; ena/link_ready: enable and synchronized link-up
// delay_req/fifo_level: target and read-side occupancy; fifo_empty/fifo_full: FIFO flags
// fifo_rst/fifo_rd_en: FIFO control; fifo_inc/fifo_dec: one-cycle trim pulses
// status: 0 IDLE 1 RESET 2 FILL 3 RUN 4 FAULT; locked: in RUN within deadband; fault_cnt: saturating
module evr_fifo_ctrl #(
  parameter int LVL_W = 10,
  parameter int RST_CYCLES = 16,
  parameter int TOL = 2,
  parameter int SETTLE = 256,
  parameter int FILL_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ena,
  input  logic             link_ready,
  input  logic [LVL_W-1:0] delay_req,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic             fifo_rst,
  output logic             fifo_rd_en,
  output logic             fifo_inc,
  output logic             fifo_dec,
  output logic [2:0]       status,
  output logic             locked,
  output logic [7:0]       fault_cnt
);
  localparam int CW = $clog2(FILL_TIMEOUT > RST_CYCLES ? FILL_TIMEOUT : RST_CYCLES) + 1;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [LVL_W:0] TV = (LVL_W+1)'(TOL);
  typedef enum logic [2:0] {IDLE = 3'd0, RST = 3'd1, FILL = 3'd2, RUN = 3'd3, FAULT = 3'd4} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic [SW-1:0] settle, settle_d;
  logic [LVL_W:0] lvl, req;
  logic hi, lo, inc_d, dec_d;
  assign lvl = {1'b0, fifo_level};
  assign req = {1'b0, delay_req};
  assign hi = lvl > req + TV;
  assign lo = lvl + TV < req;
  assign status = state;
  always_comb begin
    nxt = state;
    settle_d = settle;
    case (state)
      IDLE:  nxt = RST;
      RST:   nxt = cnt == CW'(RST_CYCLES - 1) ? FILL : RST;
      FILL: begin
        if (fifo_full) nxt = FAULT;
        else if (fifo_level >= delay_req) begin
          nxt = RUN;
          settle_d = SW'(SETTLE);
        end else if (cnt == CW'(FILL_TIMEOUT - 1)) nxt = FAULT;
      end
      RUN: begin
        nxt = fifo_empty || fifo_full ? FAULT : RUN;
        settle_d = fifo_inc || fifo_dec ? SW'(SETTLE) : settle != '0 ? settle - SW'(1) : settle;
      end
      FAULT: nxt = RST;
      default: nxt = IDLE;
    endcase
    if (!ena || !link_ready) nxt = IDLE;
    cnt_d = nxt == state ? cnt + CW'(1) : '0;
    // pulses are registered, so decide on the cycle the settle counter is about to reach 0
    inc_d = nxt == RUN && settle_d == '0 && lo;
    dec_d = nxt == RUN && settle_d == '0 && hi;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      settle     <= '0;
      fifo_rst   <= 1'b1;
      fifo_rd_en <= 1'b0;
      fifo_inc   <= 1'b0;
      fifo_dec   <= 1'b0;
      locked     <= 1'b0;
      fault_cnt  <= '0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_d;
      settle     <= settle_d;
      fifo_rst   <= nxt != FILL && nxt != RUN;
      fifo_rd_en <= nxt == RUN && !inc_d;
      fifo_inc   <= inc_d;
      fifo_dec   <= dec_d;
      locked     <= nxt == RUN && !hi && !lo;
      fault_cnt  <= fault_cnt + {7'd0, nxt == FAULT && fault_cnt != 8'hff};
    end
  end
endmodule

// File: doc/evr_fifo_ctrl.md
Name: evr_fifo_ctrl

Overview:
- Sequences the EVR elastic FIFO in the app_clk domain: startup, fill, steady-state and fault recovery.
- On link-ready it resets the FIFO and prefills it to the requested depth with reads held off. It then streams reads and trims the fill level toward target with single-slot inc (read stall) / dec (write skip request) pulses.
- It detects underflow/overflow and re-runs the startup sequence. It sits between the link-ready synchronizer and the FIFO/adjust datapath; its status feeds MMR.

Parameters:
LVL_W, 10, width of fifo_level and delay_req (FIFO depth 2**LVL_W)
RST_CYCLES, 16, cycles fifo_rst is held asserted
TOL, 2, allowed |level - target| deadband before trimming
SETTLE, 256, minimum cycles between trim pulses, and after entering RUN
FILL_TIMEOUT, 4096, max cycles in FILL before fault

Ports:
clk  in  1  app clock
resetn  in  1  asynchronous active-low reset
ena  in  1  controller enable (MMR)
link_ready  in  1  aligned && mmcm locked, already synchronized to clk
delay_req  in  LVL_W  target FIFO fill level (words)
fifo_level  in  LVL_W  read-side FIFO occupancy
fifo_empty  in  1  FIFO empty flag
fifo_full  in  1  FIFO full flag
fifo_rst  out  1  FIFO reset, active-high
fifo_rd_en  out  1  FIFO read enable
fifo_inc  out  1  one-cycle pulse: read stalled this cycle (level +1)
fifo_dec  out  1  one-cycle pulse: request write-side skip (level -1); CDC stretching is external
status  out  3  0 IDLE, 1 RESET, 2 FILL, 3 RUN, 4 FAULT
locked  out  1  RUN and |fifo_level - delay_req| <= TOL
fault_cnt  out  8  saturating count of FAULT entries

Behaviour:
- Reset (resetn=0, async): state IDLE; fifo_rst=1, fifo_rd_en=0, fifo_inc=0, fifo_dec=0, locked=0, fault_cnt=0, all counters 0. All outputs are registered.
- Global abort: if ena=0 or link_ready=0 in any state, next state is IDLE. This has priority over every other transition, including FAULT entry; fault_cnt is not incremented.
- IDLE: fifo_rst=1, rd_en=0. When ena && link_ready, go to RESET with the cycle counter cleared.
- RESET: fifo_rst=1 for exactly RST_CYCLES cycles, then go to FILL.
- FILL:
  - fifo_rst=0, rd_en=0, timeout counter running.
  - When fifo_level >= delay_req (unsigned compare, live value), go to RUN and load the settle counter with SETTLE.
  - If the counter reaches FILL_TIMEOUT first, go to FAULT.
  - If fifo_full is seen, go to FAULT.
- RUN:
  - rd_en=1 except in the cycle fifo_inc is asserted (rd_en=0 there).
  - The settle counter decrements to 0 and holds.
  - When the settle counter is 0: if level > delay_req+TOL, pulse fifo_dec one cycle; else if level + TOL < delay_req, pulse fifo_inc one cycle. Either pulse reloads the settle counter with SETTLE.
  - Compute diffs in LVL_W+1 bits; no wrap.
  - inc and dec are never asserted in the same cycle.
- FAULT:
  - Entered from RUN when fifo_empty=1 or fifo_full=1. Empty and full in the same cycle count as one fault.
  - Also entered from the FILL conditions above.
  - Lasts 1 cycle: fifo_rst=1, rd_en=0, fault_cnt += 1 saturating at 255, then go to RESET.
- delay_req changes during RUN are handled by trimming only; there is no refill.
- locked: registered, and cleared in the same cycle the state leaves RUN.

Test Plan:
- Startup: resetn released, ena=1, link_ready=1, delay_req=32, level ramps +1/cycle from 0 after fifo_rst drops -> fifo_rst high 16 cycles, status 1->2; RUN entered the cycle after level>=32; rd_en=1; locked=1; no trim pulses.
- Trim down: in RUN hold level=40, delay_req=32 -> fifo_dec pulses exactly once per 257 cycles (one pulse cycle + SETTLE), first pulse 256 cycles after RUN entry; no fifo_inc.
- Trim up: in RUN hold level=20, delay_req=32 -> fifo_inc one-cycle pulses at the same spacing, with rd_en=0 on exactly those cycles. Level 30..34 -> no pulses.
- Underflow: in RUN assert fifo_empty one cycle -> FAULT (status 4) one cycle, fault_cnt=1, then RESET 16 cycles, FILL, RUN again. Repeat 300 times -> fault_cnt saturates at 255.
- Fill timeout: level held at 0 in FILL -> FAULT after 4096 cycles, fault_cnt increments.
- Abort/reset mid-op: drop link_ready in RUN -> IDLE next cycle, fifo_rst=1, fault_cnt unchanged. Assert resetn=0 asynchronously mid-FILL -> outputs at reset values immediately, without waiting for a clock edge.
